// File: rtl/spram_led_seq_pkg.sv
// Shared definitions for spram_led_seq: controller state encodings, RAM geometry
// and the LED pattern table written into the RAM at start-up.
package spram_led_seq_pkg;

    localparam int RAM_DEPTH = 16384;
    localparam int RAM_AW    = 14;
    localparam int RAM_DW    = 16;

    typedef enum logic [7:0] {
        IDLE  = 8'd0,
        INIT0 = 8'd1,
        INIT1 = 8'd2,
        INIT2 = 8'd3,
        INIT3 = 8'd4,
        RUN   = 8'd5
    } state_e;

    localparam logic [RAM_DW-1:0] INIT_PAT0 = 16'h0001;
    localparam logic [RAM_DW-1:0] INIT_PAT1 = 16'h0002;
    localparam logic [RAM_DW-1:0] INIT_PAT2 = 16'h0004;
    localparam logic [RAM_DW-1:0] INIT_PAT3 = 16'h0007;

    // RAM slot written by each INIT state; non-INIT states map to slot 0.
    function automatic logic [1:0] init_slot(input state_e s);
        case (s)
            INIT1:   return 2'd1;
            INIT2:   return 2'd2;
            INIT3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [RAM_DW-1:0] init_pattern(input logic [1:0] slot);
        case (slot)
            2'd0:    return INIT_PAT0;
            2'd1:    return INIT_PAT1;
            2'd2:    return INIT_PAT2;
            default: return INIT_PAT3;
        endcase
    endfunction

endpackage

// File: rtl/spram_led_seq_byte_mux2.sv
// One transmit channel selector: z = sel ? a : b, purely combinational.
module byte_mux2
    import spram_led_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] z
);

    assign z = sel ? a : b;

endmodule

// File: rtl/spram_led_seq.sv
// LED sequencer that loads a 4-entry pattern into a 16Kx16 single-port RAM and
// replays it, plus per-channel tx byte selection (mux only when TX_MUX_EN is defined).
module spram_led_seq
    import spram_led_seq_pkg::*;
#(
    parameter int          UARTS  = 2,
    parameter int          DATA_W = 8,
    parameter logic [31:0] TICK   = 32'h1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [UARTS*DATA_W-1:0] rx_data,
    input  logic [UARTS*DATA_W-1:0] m_tx_data,
    input  logic [UARTS-1:0]        sel,
    output logic [UARTS*DATA_W-1:0] tx_data,
    output logic [2:0]              led
);

    state_e              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [RAM_DW-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic [2:0]          led_q, led_d;
    logic [RAM_DW-1:0]   ram_dout;
    logic [RAM_DW-1:0]   mem [RAM_DEPTH];
    logic                unused_ok;

    // ------------------------------------------------------------------ tx path
`ifdef TX_MUX_EN
    for (genvar i = 0; i < UARTS; i++) begin : g_mux
        byte_mux2 #(.DATA_W(DATA_W)) u_mux (
            .a  (rx_data[i*DATA_W +: DATA_W]),
            .b  (m_tx_data[i*DATA_W +: DATA_W]),
            .sel(sel[i]),
            .z  (tx_data[i*DATA_W +: DATA_W])
        );
    end
    assign unused_ok = ^ram_dout[RAM_DW-1:3];
`else
    assign tx_data   = rx_data;
    assign unused_ok = ^{ram_dout[RAM_DW-1:3], sel, m_tx_data};
`endif

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            INIT0:   state_d = INIT1;
            INIT1:   state_d = INIT2;
            INIT2:   state_d = INIT3;
            INIT3:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        we_d   = 1'b0;
        din_d  = din_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        case (state_q)
            INIT0, INIT1, INIT2, INIT3: begin
                we_d   = 1'b1;
                addr_d = {{(RAM_AW-2){1'b0}}, init_slot(state_q)};
                din_d  = init_pattern(init_slot(state_q));
            end
            RUN: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == TICK) begin
                    addr_d = {{(RAM_AW-2){1'b0}}, addr_q[1:0] + 2'd1};
                end else if (we_q) begin
                    // Last INIT write drains this cycle; park at slot 0 so the first tick reads slot 1.
                    addr_d = '0;
                end
                if (cnt_q == TICK + 32'd2) begin
                    led_d = ram_dout[2:0];
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
            led_q  <= 3'b000;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= we_d;
            led_q  <= led_d;
        end
    end

    // ------------------------------------------------------------------ RAM
    // NOTE: the array and its read register have no reset; contents are rewritten by INIT before use.
    always_ff @(posedge clk) begin
        if (we_q) begin
            mem[addr_q] <= din_q;
        end
        ram_dout <= mem[addr_q];
    end

    assign led = led_q;

endmodule

// File: tb/tb_spram_led_seq.sv
// Directed self-checking bench for spram_led_seq with TICK=8; expectations follow the
// TX_MUX_EN setting of the build.
module tb_spram_led_seq;
    import spram_led_seq_pkg::*;

    localparam int          UARTS  = 2;
    localparam int          DATA_W = 8;
    localparam logic [31:0] TICK   = 32'd8;
    localparam int          PERIOD = 11;  // TICK+3

    logic                    clk;
    logic                    rst_n;
    logic [UARTS*DATA_W-1:0] rx_data;
    logic [UARTS*DATA_W-1:0] m_tx_data;
    logic [UARTS-1:0]        sel;
    logic [UARTS*DATA_W-1:0] tx_data;
    logic [2:0]              led;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] max_cnt;
    logic        clr_max;

    spram_led_seq #(.UARTS(UARTS), .DATA_W(DATA_W), .TICK(TICK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .m_tx_data(m_tx_data),
        .sel      (sel),
        .tx_data  (tx_data),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_max) max_cnt <= '0;
        else if (rst_n && dut.cnt_q > max_cnt) max_cnt <= dut.cnt_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_led(input int k);
        case (k % 4)
            0:       return 3'b010;
            1:       return 3'b100;
            2:       return 3'b111;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [15:0] exp_tx(input logic [1:0] s);
`ifdef TX_MUX_EN
        case (s)
            2'b00:   return 16'hC3A5;
            2'b01:   return 16'hC33C;
            2'b10:   return 16'h5AA5;
            default: return 16'h5A3C;
        endcase
`else
        return (s == 2'b00) ? 16'h5A3C : 16'h5A3C;
`endif
    endfunction

    // Release reset at a falling edge, then walk INIT0..INIT3 into RUN.
    task automatic release_and_init(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check({tag, "_st1"}, 32'(dut.state_q), 32'(INIT1));
        check({tag, "_we1"}, 32'(dut.we_q), 32'd1);
        step(3);
        check({tag, "_st4"}, 32'(dut.state_q), 32'(RUN));
        check({tag, "_cnt4"}, dut.cnt_q, 32'd0);
        step(1);
        check({tag, "_we5"}, 32'(dut.we_q), 32'd0);
        step(9);  // edge 14: counter at TICK+2, led not yet loaded
        check({tag, "_led_pre"}, 32'(led), 32'd0);
        check({tag, "_cnt14"}, dut.cnt_q, TICK + 32'd2);
        step(1);  // edge 15: first LED step
        check({tag, "_led0"}, 32'(led), 32'(exp_led(0)));
        check({tag, "_cnt15"}, dut.cnt_q, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr_max   = 1'b1;
        rx_data   = 16'h5A3C;
        m_tx_data = 16'hC3A5;
        sel       = 2'b00;

        #12;
        check("rst_led", 32'(led), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(INIT0));
        check("rst_cnt", dut.cnt_q, 32'd0);
        check("rst_we", 32'(dut.we_q), 32'd0);
        check("rst_addr", 32'(dut.addr_q), 32'd0);

        release_and_init("boot");

        // Tx selection is combinational: each sel pattern is visible in the same cycle.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check($sformatf("mux_sel%0d", s), 32'(tx_data), 32'(exp_tx(2'(s))));
        end
        m_tx_data = 16'h0000;
        sel       = 2'b00;
        #1;
`ifdef TX_MUX_EN
        check("mux_mtx_zero", 32'(tx_data), 32'h0000);
`else
        check("loop_mtx_zero", 32'(tx_data), 32'h5A3C);
`endif
        m_tx_data = 16'hC3A5;

        step(PERIOD - 1);
        check("step1_hold", 32'(led), 32'(exp_led(0)));
        step(1);
        check("step1", 32'(led), 32'(exp_led(1)));

        // Asynchronous reset off the clock edge while led = 3'b100.
        step(3);
        #2;
        sel   = 2'b01;
        rst_n = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 32'd0);
        check("mid_rst_cnt", dut.cnt_q, 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(INIT0));
        check("mid_rst_tx", 32'(tx_data), 32'(exp_tx(2'b01)));

        release_and_init("restart");
        for (int k = 1; k <= 4; k++) begin
            step(PERIOD);
            check($sformatf("seq_step%0d", k), 32'(led), 32'(exp_led(k)));
        end

        // Twenty further steps while tracking the largest counter value seen.
        clr_max = 1'b1;
        step(1);
        clr_max = 1'b0;
        step(20 * PERIOD - 1);
        check("bound_led", 32'(led), 32'(exp_led(24)));
        check("bound_max_cnt", max_cnt, TICK + 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
